// File: rtl/lsc_ml_class_filter_pkg.sv
// Shared definitions for the CNN class post-processor: NONE encoding, index
// width helper and the stability-stage action codes.
package lsc_ml_class_filter_pkg;

  // Smallest r with 2**r >= value; used to size class indices.
  function automatic int clog2_fn(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // NONE is encoded as index == NUM_CLASS, so the index width must hold NUM_CLASS.
  function automatic int none_code(input int num_class);
    return num_class;
  endfunction

  typedef enum logic [1:0] {
    STAB_HOLD    = 2'd0,
    STAB_INC     = 2'd1,
    STAB_RESTART = 2'd2,
    STAB_CLEAR   = 2'd3
  } stab_act_e;

endpackage

// File: rtl/lsc_ml_stable_filter.sv
// Temporal stability filter: tracks how many consecutive frames repeated the
// same candidate and switches the debounced class once that run is long enough.
module lsc_ml_stable_filter
  import lsc_ml_class_filter_pkg::*;
#(
  parameter int NUM_CLASS  = 4,
  parameter int CLS_W      = clog2_fn(NUM_CLASS + 1),
  parameter int CNT_W      = 4,
  parameter int STABLE_CNT = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_clear,
  input  logic                 i_vld,
  input  logic [CLS_W-1:0]     i_cand,
  output logic [CLS_W-1:0]     o_class,
  output logic [NUM_CLASS-1:0] o_onehot,
  output logic                 o_upd,
  output logic [CNT_W-1:0]     o_stable
);

  localparam logic [CLS_W-1:0] NONE     = CLS_W'(none_code(NUM_CLASS));
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] STABLE_V = CNT_W'(STABLE_CNT);

  logic [CLS_W-1:0]     r_last;
  logic [CLS_W-1:0]     r_class;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_CLASS-1:0] r_onehot;
  logic                 r_upd;
  logic [NUM_CLASS-1:0] w_onehot;
  logic                 w_switch;
  stab_act_e            w_act;

  always_comb begin
    w_act = STAB_HOLD;
    if (i_clear) begin
      w_act = STAB_CLEAR;
    end else if (i_vld) begin
      w_act = (i_cand == r_last) ? STAB_INC : STAB_RESTART;
    end
  end

  // The switch looks at the registered last/cnt, so it lands one cycle after
  // the count update; a clear in that cycle suppresses it.
  assign w_switch = (w_act != STAB_CLEAR) && (r_cnt >= STABLE_V) && (r_last != r_class);

  always_comb begin
    w_onehot = '0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      w_onehot[k] = (r_last == CLS_W'(k));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last   <= NONE;
      r_cnt    <= '0;
      r_class  <= NONE;
      r_onehot <= '0;
      r_upd    <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      case (w_act)
        STAB_CLEAR: begin
          r_last   <= NONE;
          r_cnt    <= '0;
          r_class  <= NONE;
          r_onehot <= '0;
        end
        STAB_INC: begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        end
        STAB_RESTART: begin
          r_cnt  <= '0;
          r_last <= i_cand;
        end
        default: ;
      endcase
      if (w_switch) begin
        r_class  <= r_last;
        r_onehot <= w_onehot;
        r_upd    <= 1'b1;
      end
    end
  end

  assign o_class  = r_class;
  assign o_onehot = r_onehot;
  assign o_upd    = r_upd;
  assign o_stable = r_cnt;

endmodule

// File: rtl/lsc_ml_class_filter.sv
// CNN classifier post-processor: running argmax over NUM_CLASS signed scores
// with negative rejection and a confidence margin, followed by a stability filter.
module lsc_ml_class_filter
  import lsc_ml_class_filter_pkg::*;
#(
  parameter int          NUM_CLASS     = 4,
  parameter int          SCORE_W       = 16,
  parameter int unsigned MARGIN        = 0,
  parameter int          EN_NEG_REJECT = 1,
  parameter int          STABLE_CNT    = 2,
  parameter int          CNT_W         = 4,
  parameter int          CLS_W         = clog2_fn(NUM_CLASS + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_start,
  input  logic                 i_clear,
  input  logic                 i_we,
  input  logic [SCORE_W-1:0]   i_din,
  output logic                 o_frame_done,
  output logic [CLS_W-1:0]     o_cand,
  output logic [SCORE_W-1:0]   o_best,
  output logic [CLS_W-1:0]     o_class,
  output logic [NUM_CLASS-1:0] o_onehot,
  output logic                 o_upd,
  output logic [CNT_W-1:0]     o_stable
);

  localparam logic [CLS_W-1:0] NONE     = CLS_W'(none_code(NUM_CLASS));
  localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(NUM_CLASS - 1);
  localparam logic [31:0]      MARGIN_V = 32'(MARGIN);

  // Score stream: i_we is a one-cycle valid strobe with no back-pressure; every
  // strobe is consumed in the cycle it is sampled and i_start may share that cycle.
  logic [CLS_W-1:0]          r_idx;
  logic signed [SCORE_W-1:0] r_best;
  logic [CLS_W-1:0]          r_best_idx;
  logic                      r_best_vld;
  logic signed [SCORE_W-1:0] r_sec;
  logic                      r_sec_vld;
  logic                      r_done;
  logic [CLS_W-1:0]          r_cand;
  logic [SCORE_W-1:0]        r_best_out;

  logic [CLS_W-1:0]          w_idx;
  logic                      w_b_vld;
  logic                      w_s_vld;
  logic                      w_elig;
  logic                      w_last;
  logic signed [SCORE_W-1:0] w_n_best;
  logic [CLS_W-1:0]          w_n_best_idx;
  logic                      w_n_best_vld;
  logic signed [SCORE_W-1:0] w_n_sec;
  logic                      w_n_sec_vld;
  logic [SCORE_W:0]          w_diff;
  logic                      w_short;
  logic [CLS_W-1:0]          w_cand;

  assign w_elig = (EN_NEG_REJECT == 0) || !i_din[SCORE_W-1];

  always_comb begin
    w_idx        = i_start ? '0 : r_idx;
    w_b_vld      = r_best_vld && !i_start;
    w_s_vld      = r_sec_vld && !i_start;
    w_n_best     = r_best;
    w_n_best_idx = r_best_idx;
    w_n_best_vld = w_b_vld;
    w_n_sec      = r_sec;
    w_n_sec_vld  = w_s_vld;
    if (i_we && w_elig) begin
      // Strict comparisons keep ties on the lower index.
      if (!w_b_vld || ($signed(i_din) > r_best)) begin
        w_n_sec      = r_best;
        w_n_sec_vld  = w_b_vld;
        w_n_best     = $signed(i_din);
        w_n_best_idx = w_idx;
        w_n_best_vld = 1'b1;
      end else if (!w_s_vld || ($signed(i_din) > r_sec)) begin
        w_n_sec     = $signed(i_din);
        w_n_sec_vld = 1'b1;
      end
    end
  end

  assign w_last = i_we && (w_idx == LAST_IDX);

  // One extra bit keeps best - second from overflowing; it is never negative.
  assign w_diff  = {w_n_best[SCORE_W-1], w_n_best} - {w_n_sec[SCORE_W-1], w_n_sec};
  assign w_short = w_n_sec_vld && ({{(31 - SCORE_W){1'b0}}, w_diff} < MARGIN_V);
  assign w_cand  = (!w_n_best_vld || w_short) ? NONE : w_n_best_idx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idx      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_best_vld <= 1'b0;
      r_sec      <= '0;
      r_sec_vld  <= 1'b0;
      r_done     <= 1'b0;
      r_cand     <= NONE;
      r_best_out <= '0;
    end else begin
      r_done     <= w_last;
      r_best     <= w_n_best;
      r_best_idx <= w_n_best_idx;
      r_sec      <= w_n_sec;
      r_best_vld <= w_n_best_vld && !w_last;
      r_sec_vld  <= w_n_sec_vld && !w_last;
      if (i_we) begin
        r_idx <= w_last ? '0 : w_idx + 1'b1;
      end else begin
        r_idx <= w_idx;
      end
      if (w_last) begin
        r_cand     <= w_cand;
        r_best_out <= w_n_best_vld ? w_n_best : '0;
      end
    end
  end

  lsc_ml_stable_filter #(
    .NUM_CLASS  (NUM_CLASS),
    .CLS_W      (CLS_W),
    .CNT_W      (CNT_W),
    .STABLE_CNT (STABLE_CNT)
  ) u_stable (
    .clk      (clk),
    .resetn   (resetn),
    .i_clear  (i_clear),
    .i_vld    (r_done),
    .i_cand   (r_cand),
    .o_class  (o_class),
    .o_onehot (o_onehot),
    .o_upd    (o_upd),
    .o_stable (o_stable)
  );

  assign o_frame_done = r_done;
  assign o_cand       = r_cand;
  assign o_best       = r_best_out;

endmodule

// File: tb/tb_lsc_ml_class_filter.sv
// Self-checking bench: three configurations (defaults, no negative reject,
// MARGIN=50) share one stimulus stream and are compared to a frame-level model.
module tb_lsc_ml_class_filter;

  localparam int NC = 4, SW = 16, CW = 3, NW = 4, NONE = 4, ND = 3;
  typedef int frame_t[NC];

  logic clk, resetn, i_start, i_clear, i_we;
  logic [SW-1:0] i_din;
  logic [ND-1:0] o_done, o_upd_v;
  logic [ND-1:0][CW-1:0] o_cand_v, o_class_v;
  logic [ND-1:0][SW-1:0] o_best_v;
  logic [ND-1:0][NC-1:0] o_oh_v;
  logic [ND-1:0][NW-1:0] o_stab_v;

  logic [ND-1:0] ob_done1, ob_done2, ob_upd;
  logic [ND-1:0][CW-1:0] ob_cand, ob_cls;
  logic [ND-1:0][SW-1:0] ob_best;
  logic [ND-1:0][NC-1:0] ob_oh;
  logic [ND-1:0][NW-1:0] ob_stab;

  int cfg_neg[ND] = '{1, 0, 1};
  int cfg_margin[ND] = '{0, 0, 50};
  int n_tests = 0, n_fail = 0, done_cnt = 0;
  int st_last[ND], st_cnt[ND], st_cls[ND], st_upd[ND];
  int ex_cand[ND], ex_best[ND];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (o_done[0]) done_cnt <= done_cnt + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  lsc_ml_class_filter dut0 (
    .clk(clk), .resetn(resetn), .i_start(i_start), .i_clear(i_clear), .i_we(i_we), .i_din(i_din),
    .o_frame_done(o_done[0]), .o_cand(o_cand_v[0]), .o_best(o_best_v[0]), .o_class(o_class_v[0]),
    .o_onehot(o_oh_v[0]), .o_upd(o_upd_v[0]), .o_stable(o_stab_v[0]));

  lsc_ml_class_filter #(.EN_NEG_REJECT(0)) dut1 (
    .clk(clk), .resetn(resetn), .i_start(i_start), .i_clear(i_clear), .i_we(i_we), .i_din(i_din),
    .o_frame_done(o_done[1]), .o_cand(o_cand_v[1]), .o_best(o_best_v[1]), .o_class(o_class_v[1]),
    .o_onehot(o_oh_v[1]), .o_upd(o_upd_v[1]), .o_stable(o_stab_v[1]));

  lsc_ml_class_filter #(.MARGIN(50)) dut2 (
    .clk(clk), .resetn(resetn), .i_start(i_start), .i_clear(i_clear), .i_we(i_we), .i_din(i_din),
    .o_frame_done(o_done[2]), .o_cand(o_cand_v[2]), .o_best(o_best_v[2]), .o_class(o_class_v[2]),
    .o_onehot(o_oh_v[2]), .o_upd(o_upd_v[2]), .o_stable(o_stab_v[2]));

  // ---------------- reference model ----------------
  function automatic void model_frame(input frame_t s, input int d, output int c, output int b);
    int bi, sv;
    bit sf;
    bi = -1; sv = 0; sf = 0;
    for (int k = 0; k < NC; k++)
      if ((cfg_neg[d] == 0 || s[k] >= 0) && (bi < 0 || s[k] > s[bi])) bi = k;
    for (int k = 0; k < NC; k++)
      if (k != bi && (cfg_neg[d] == 0 || s[k] >= 0) && (!sf || s[k] > sv)) begin
        sv = s[k]; sf = 1;
      end
    if (bi < 0) begin
      c = NONE; b = 0;
    end else begin
      b = s[bi];
      c = (sf && (s[bi] - sv) < cfg_margin[d]) ? NONE : bi;
    end
  endfunction

  function automatic void model_stab(input int d, input int c, input bit clr);
    int prev;
    prev = st_cls[d];
    if (clr) begin
      st_last[d] = NONE; st_cnt[d] = 0; st_cls[d] = NONE;
    end else begin
      if (c == st_last[d]) st_cnt[d] = (st_cnt[d] == 15) ? 15 : st_cnt[d] + 1;
      else begin st_cnt[d] = 0; st_last[d] = c; end
      if (st_cnt[d] >= 2 && st_last[d] != st_cls[d]) st_cls[d] = st_last[d];
    end
    st_upd[d] = (!clr && st_cls[d] != prev) ? 1 : 0;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < ND; d++) begin
      st_last[d] = NONE; st_cnt[d] = 0; st_cls[d] = NONE; st_upd[d] = 0;
    end
  endfunction

  function automatic logic [NC-1:0] oh_of(input int c);
    logic [NC-1:0] v;
    v = '0;
    if (c < NC) v[c] = 1'b1;
    return v;
  endfunction

  function automatic frame_t rand_frame();
    frame_t s;
    for (int k = 0; k < NC; k++) s[k] = int'($urandom_range(1200, 0)) - 200;
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  // Drives one frame and captures outputs at T+1, T+2 and T+3.
  task automatic run_frame(input frame_t s, input int max_gap, input bit clr);
    for (int k = 0; k < NC; k++) begin
      repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
      i_we = 1'b1; i_din = SW'(s[k]);
      @(posedge clk); #1;
      i_we = 1'b0; i_start = 1'b0;
    end
    ob_done1 = o_done; ob_cand = o_cand_v; ob_best = o_best_v;
    for (int d = 0; d < ND; d++) begin
      model_frame(s, d, ex_cand[d], ex_best[d]);
      model_stab(d, ex_cand[d], clr);
    end
    i_clear = clr;
    @(posedge clk); #1;
    i_clear = 1'b0;
    ob_done2 = o_done; ob_stab = o_stab_v;
    @(posedge clk); #1;
    ob_cls = o_class_v; ob_oh = o_oh_v; ob_upd = o_upd_v;
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    @(posedge clk); #1;
    i_clear = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    for (int d = 0; d < ND; d++) begin
      n_tests++;
      if ({o_cand_v[d], o_best_v[d], o_class_v[d], o_oh_v[d], o_upd_v[d], o_stab_v[d], o_done[d]} !==
          {3'd4, 16'd0, 3'd4, 4'd0, 1'b0, 4'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_held dut%0d: got %h expected %h", d,
                 {o_cand_v[d], o_best_v[d], o_class_v[d], o_oh_v[d], o_upd_v[d], o_stab_v[d], o_done[d]},
                 {3'd4, 16'd0, 3'd4, 4'd0, 1'b0, 4'd0, 1'b0});
      end
    end
    #10 resetn = 1'b1;
    @(posedge clk); #1;
    model_reset();
    for (int d = 0; d < ND; d++) begin
      n_tests++;
      if ({o_cand_v[d], o_class_v[d], o_stab_v[d], o_done[d]} !== {3'd4, 3'd4, 4'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_released dut%0d: got %h expected %h", d,
                 {o_cand_v[d], o_class_v[d], o_stab_v[d], o_done[d]}, {3'd4, 3'd4, 4'd0, 1'b0});
      end
    end
  endtask

  task automatic test_basic();
    frame_t s = '{100, 300, 200, 50};
    for (int f = 1; f <= 3; f++) begin
      run_frame(s, 1, 1'b0);
      for (int d = 0; d < ND; d++) begin
        n_tests++;
        if (ob_cand[d] !== CW'(ex_cand[d]) || ob_best[d] !== SW'(ex_best[d]) || ob_done1[d] !== 1'b1) begin
          n_fail++;
          $display("FAIL basic_frame dut%0d f%0d: cand %0d best %0d done %b, expected %0d %0d 1",
                   d, f, ob_cand[d], $signed(ob_best[d]), ob_done1[d], ex_cand[d], ex_best[d]);
        end
      end
      n_tests++;
      if (ob_done2[0] !== 1'b0 || ob_stab[0] !== NW'(st_cnt[0]) || ob_cls[0] !== CW'(st_cls[0]) ||
          ob_upd[0] !== st_upd[0][0]) begin
        n_fail++;
        $display("FAIL basic_stab f%0d: done2 %b stable %0d class %0d upd %b, expected 0 %0d %0d %0d",
                 f, ob_done2[0], ob_stab[0], ob_cls[0], ob_upd[0], st_cnt[0], st_cls[0], st_upd[0]);
      end
    end
    n_tests++;
    if (ob_cls[0] !== 3'd1 || ob_upd[0] !== 1'b1 || ob_oh[0] !== 4'b0010) begin
      n_fail++;
      $display("FAIL basic_switch: class %0d upd %b onehot %b, expected 1 1 0010", ob_cls[0], ob_upd[0], ob_oh[0]);
    end
  endtask

  task automatic test_tie();
    run_frame('{200, 200, -5, 0}, 0, 1'b0);
    for (int d = 0; d < ND; d++) begin
      n_tests++;
      if (ob_cand[d] !== CW'(ex_cand[d])) begin
        n_fail++;
        $display("FAIL tie_cand dut%0d: got %0d expected %0d", d, ob_cand[d], ex_cand[d]);
      end
    end
    n_tests++;
    if (ob_cand[0] !== 3'd0) begin
      n_fail++;
      $display("FAIL tie_lower_index: got %0d expected 0", ob_cand[0]);
    end
  endtask

  task automatic test_negative();
    run_frame('{-1, -7, -3, -2}, 2, 1'b0);
    n_tests++;
    if (ob_cand[0] !== 3'd4 || ob_best[0] !== 16'd0) begin
      n_fail++;
      $display("FAIL neg_reject: cand %0d best %0d, expected 4 0", ob_cand[0], $signed(ob_best[0]));
    end
    n_tests++;
    if (ob_cand[1] !== 3'd0 || ob_best[1] !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL neg_plain: cand %0d best %0d, expected 0 -1", ob_cand[1], $signed(ob_best[1]));
    end
  endtask

  task automatic test_margin();
    run_frame('{10, 120, 100, 0}, 0, 1'b0);
    n_tests++;
    if (ob_cand[2] !== 3'd4 || ob_cand[0] !== 3'd1) begin
      n_fail++;
      $display("FAIL margin_short: m50 cand %0d m0 cand %0d, expected 4 1", ob_cand[2], ob_cand[0]);
    end
    run_frame('{10, 160, 100, 0}, 1, 1'b0);
    n_tests++;
    if (ob_cand[2] !== 3'd1 || ob_best[2] !== 16'd160) begin
      n_fail++;
      $display("FAIL margin_ok: cand %0d best %0d, expected 1 160", ob_cand[2], ob_best[2]);
    end
  endtask

  task automatic test_stability();
    frame_t c1 = '{0, 50, 0, 0};
    frame_t c2 = '{0, 0, 50, 0};
    pulse_clear();
    for (int f = 1; f <= 5; f++) begin
      run_frame((f <= 2) ? c1 : c2, 1, 1'b0);
      for (int d = 0; d < ND; d++) begin
        n_tests++;
        if (ob_stab[d] !== NW'(st_cnt[d]) || ob_cls[d] !== CW'(st_cls[d]) || ob_oh[d] !== oh_of(st_cls[d])) begin
          n_fail++;
          $display("FAIL stab_model dut%0d f%0d: stable %0d class %0d onehot %b, expected %0d %0d %b",
                   d, f, ob_stab[d], ob_cls[d], ob_oh[d], st_cnt[d], st_cls[d], oh_of(st_cls[d]));
        end
      end
      if (f == 3) begin
        n_tests++;
        if (ob_stab[0] !== 4'd0) begin
          n_fail++;
          $display("FAIL stab_restart: stable %0d expected 0", ob_stab[0]);
        end
      end
      n_tests++;
      if (ob_cls[0] !== ((f < 5) ? 3'd4 : 3'd2) || ob_upd[0] !== (f == 5)) begin
        n_fail++;
        $display("FAIL stab_class f%0d: class %0d upd %b", f, ob_cls[0], ob_upd[0]);
      end
    end
  endtask

  task automatic test_mid_start();
    int base;
    base = done_cnt;
    for (int k = 0; k < 2; k++) begin
      i_we = 1'b1; i_din = SW'(k + 5);
      @(posedge clk); #1;
      i_we = 1'b0;
    end
    i_start = 1'b1;
    run_frame('{0, 0, 9, 0}, 0, 1'b0);
    n_tests++;
    if (done_cnt - base !== 1 || ob_cand[0] !== 3'd2) begin
      n_fail++;
      $display("FAIL mid_start: pulses %0d cand %0d, expected 1 2", done_cnt - base, ob_cand[0]);
    end
    for (int d = 0; d < ND; d++) begin
      n_tests++;
      if (ob_cand[d] !== CW'(ex_cand[d])) begin
        n_fail++;
        $display("FAIL mid_start_cand dut%0d: got %0d expected %0d", d, ob_cand[d], ex_cand[d]);
      end
    end
  endtask

  task automatic test_clear();
    frame_t c1 = '{0, 50, 0, 0};
    pulse_clear();
    for (int f = 0; f < 3; f++) run_frame(c1, 0, 1'b0);
    n_tests++;
    if (ob_cls[0] !== 3'd1) begin
      n_fail++;
      $display("FAIL clear_setup: class %0d expected 1", ob_cls[0]);
    end
    run_frame(c1, 0, 1'b1);
    n_tests++;
    if (ob_stab[0] !== 4'd0 || ob_cls[0] !== 3'd4 || ob_oh[0] !== 4'd0 || ob_upd[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_collision: stable %0d class %0d onehot %b upd %b, expected 0 4 0000 0",
               ob_stab[0], ob_cls[0], ob_oh[0], ob_upd[0]);
    end
    n_tests++;
    if (ob_cand[0] !== 3'd1 || ob_done1[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_frame_completes: cand %0d done %b, expected 1 1", ob_cand[0], ob_done1[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] exp_q[$];
    frame_t fr[6];
    int c, b;
    for (int f = 0; f < 6; f++) begin
      fr[f] = (f > 0 && $urandom_range(1, 0) == 1) ? fr[f-1] : rand_frame();
      model_frame(fr[f], 0, c, b);
      exp_q.push_back(CW'(c));
      for (int d = 0; d < ND; d++) begin
        model_frame(fr[f], d, c, b);
        model_stab(d, c, 1'b0);
      end
    end
    fork
      begin
        for (int f = 0; f < 6; f++)
          for (int k = 0; k < NC; k++) begin
            i_we = 1'b1; i_din = SW'(fr[f][k]);
            @(posedge clk); #1;
          end
        i_we = 1'b0;
      end
      begin
        logic [CW-1:0] e;
        for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
          @(negedge clk);
          if (o_done[0]) begin
            e = exp_q.pop_front();
            n_tests++;
            if (o_cand_v[0] !== e) begin
              n_fail++;
              $display("FAIL b2b_cand: got %0d expected %0d", o_cand_v[0], e);
            end
          end
        end
      end
    join
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_timeout: %0d frames never completed, expected 0", exp_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      n_tests++;
      if (o_class_v[d] !== CW'(st_cls[d]) || o_stab_v[d] !== NW'(st_cnt[d])) begin
        n_fail++;
        $display("FAIL b2b_stab dut%0d: class %0d stable %0d, expected %0d %0d",
                 d, o_class_v[d], o_stab_v[d], st_cls[d], st_cnt[d]);
      end
    end
  endtask

  task automatic test_random();
    frame_t s;
    bit clr;
    s = rand_frame();
    for (int f = 0; f < 16; f++) begin
      if ($urandom_range(9, 0) < 6) s = rand_frame();
      clr = ($urandom_range(7, 0) == 0);
      run_frame(s, 2, clr);
      for (int d = 0; d < ND; d++) begin
        n_tests++;
        if (ob_cand[d] !== CW'(ex_cand[d]) || ob_best[d] !== SW'(ex_best[d]) ||
            ob_done1[d] !== 1'b1 || ob_done2[d] !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_frame dut%0d f%0d: cand %0d best %0d done %b%b, expected %0d %0d 10",
                   d, f, ob_cand[d], $signed(ob_best[d]), ob_done1[d], ob_done2[d], ex_cand[d], ex_best[d]);
        end
        n_tests++;
        if (ob_stab[d] !== NW'(st_cnt[d]) || ob_cls[d] !== CW'(st_cls[d]) ||
            ob_oh[d] !== oh_of(st_cls[d]) || ob_upd[d] !== st_upd[d][0]) begin
          n_fail++;
          $display("FAIL rand_stab dut%0d f%0d: stable %0d class %0d onehot %b upd %b, expected %0d %0d %b %0d",
                   d, f, ob_stab[d], ob_cls[d], ob_oh[d], ob_upd[d], st_cnt[d], st_cls[d], oh_of(st_cls[d]), st_upd[d]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      i_we = 1'b1; i_din = SW'(300 + k);
      @(posedge clk); #1;
      i_we = 1'b0;
    end
    #2 resetn = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      n_tests++;
      if ({o_cand_v[d], o_best_v[d], o_class_v[d], o_oh_v[d], o_upd_v[d], o_stab_v[d], o_done[d]} !==
          {3'd4, 16'd0, 3'd4, 4'd0, 1'b0, 4'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_mid dut%0d: got %h expected %h", d,
                 {o_cand_v[d], o_best_v[d], o_class_v[d], o_oh_v[d], o_upd_v[d], o_stab_v[d], o_done[d]},
                 {3'd4, 16'd0, 3'd4, 4'd0, 1'b0, 4'd0, 1'b0});
      end
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    model_reset();
    run_frame(rand_frame(), 1, 1'b0);
    for (int d = 0; d < ND; d++) begin
      n_tests++;
      if (ob_cand[d] !== CW'(ex_cand[d]) || ob_stab[d] !== NW'(st_cnt[d])) begin
        n_fail++;
        $display("FAIL reset_mid_after dut%0d: cand %0d stable %0d, expected %0d %0d",
                 d, ob_cand[d], ob_stab[d], ex_cand[d], st_cnt[d]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    resetn = 1'b0; i_start = 1'b0; i_clear = 1'b0; i_we = 1'b0; i_din = '0;
    model_reset();
    test_reset();
    test_basic();
    test_tie();
    test_negative();
    test_margin();
    test_stability();
    test_mid_start();
    test_clear();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
